// File: rtl/qduc_cfg_sequencer.sv
// Configuration sequencer for the QDUC: accepts tuner settings over valid/ready and
// applies them on a CIC1 rate boundary, muting and draining the chain for disruptive changes.
module qduc_cfg_sequencer #(
   parameter int unsigned ISZ           = 16,
   parameter int unsigned FSZ           = 31,
   parameter int unsigned DRAIN_CYCLES  = 512,
   parameter int unsigned SETTLE_CYCLES = 512,
   parameter int unsigned CW            = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sync_stb,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [FSZ-1:0]        cfg_lo_freq,
   input  logic                  cfg_lo_dir,
   input  logic                  cfg_lo_ns_en,
   input  logic                  cfg_iq_swap,
   input  logic                  cfg_tuner_byp,
   input  logic signed [ISZ-1:0] in_i,
   input  logic signed [ISZ-1:0] in_q,
   output logic signed [ISZ-1:0] out_i,
   output logic signed [ISZ-1:0] out_q,
   output logic [FSZ-1:0]        lo_freq,
   output logic                  lo_dir,
   output logic                  lo_ns_en,
   output logic                  iq_swap,
   output logic                  tuner_byp,
   output logic                  busy,
   output logic                  applied_stb
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SYNC_G,
      MUTE_WAIT,
      DRAIN,
      APPLY,
      SETTLE,
      SETTLE_SYNC
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  cnt_d;
   logic [1:0]     rst_sync;
   logic           rst_n;
   logic           xfer;
   logic           disr;
   logic           apply;
   logic           mute_d;
   logic           busy_d;

   logic [FSZ-1:0] sh_freq;
   logic           sh_dir;
   logic           sh_ns_en;
   logic           sh_iq_swap;
   logic           sh_tuner_byp;
   logic           sh_disr;

   // Asynchronous assertion, synchronous release of the internal reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];
   assign xfer  = cfg_valid && cfg_ready;
   assign disr  = (cfg_iq_swap != iq_swap) || (cfg_tuner_byp != tuner_byp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter and mute decision for the cycle after this one
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      apply   = 1'b0;
      mute_d  = 1'b0;
      busy_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) state_d = disr ? MUTE_WAIT : WAIT_SYNC_G;
         end
         WAIT_SYNC_G: begin
            if (sync_stb) state_d = APPLY;
         end
         MUTE_WAIT: begin
            if (sync_stb) begin
               state_d = DRAIN;
               cnt_d   = CW'(DRAIN_CYCLES - 1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) state_d = APPLY;
            else             cnt_d   = cnt_q - CW'(1);
         end
         APPLY: begin
            apply = 1'b1;
            if (sh_disr) begin
               state_d = SETTLE;
               cnt_d   = CW'(SETTLE_CYCLES - 1);
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = SETTLE_SYNC;
            else             cnt_d   = cnt_q - CW'(1);
         end
         SETTLE_SYNC: begin
            if (sync_stb) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      mute_d = (state_d inside {MUTE_WAIT, DRAIN, SETTLE, SETTLE_SYNC}) ||
               ((state_d == APPLY) && sh_disr);
      // busy spans capture through the cycle the new controls become visible
      busy_d = (state_d != IDLE) || (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready   <= 1'b0;
         busy        <= 1'b0;
         applied_stb <= 1'b0;
         out_i       <= '0;
         out_q       <= '0;
      end else begin
         cfg_ready   <= !busy_d;
         busy        <= busy_d;
         applied_stb <= apply;
         out_i       <= mute_d ? '0 : in_i;
         out_q       <= mute_d ? '0 : in_q;
      end
   end

   // Shadow capture on handshake; classification is frozen with the capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_freq      <= '0;
         sh_dir       <= 1'b0;
         sh_ns_en     <= 1'b0;
         sh_iq_swap   <= 1'b0;
         sh_tuner_byp <= 1'b0;
         sh_disr      <= 1'b0;
      end else if (xfer) begin
         sh_freq      <= cfg_lo_freq;
         sh_dir       <= cfg_lo_dir;
         sh_ns_en     <= cfg_lo_ns_en;
         sh_iq_swap   <= cfg_iq_swap;
         sh_tuner_byp <= cfg_tuner_byp;
         sh_disr      <= disr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_freq   <= '0;
         lo_dir    <= 1'b0;
         lo_ns_en  <= 1'b0;
         iq_swap   <= 1'b0;
         tuner_byp <= 1'b0;
      end else if (apply) begin
         lo_freq   <= sh_freq;
         lo_dir    <= sh_dir;
         lo_ns_en  <= sh_ns_en;
         iq_swap   <= sh_iq_swap;
         tuner_byp <= sh_tuner_byp;
      end
   end

endmodule

// File: tb/tb_qduc_cfg_sequencer.sv
// Scoreboard bench for qduc_cfg_sequencer: captured configs are queued and
// matched against the applied controls whenever applied_stb pulses.
module tb_qduc_cfg_sequencer;

   localparam int unsigned ISZ = 16;
   localparam int unsigned FSZ = 31;
   localparam int unsigned DRN = 8;
   localparam int unsigned STL = 8;

   typedef struct packed {
      logic [FSZ-1:0] f;
      logic           dir;
      logic           ns;
      logic           sw;
      logic           byp;
   } cfg_t;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  sync_stb = 1'b0;
   logic                  cfg_valid = 1'b0;
   logic                  cfg_ready;
   logic [FSZ-1:0]        cfg_lo_freq;
   logic                  cfg_lo_dir;
   logic                  cfg_lo_ns_en;
   logic                  cfg_iq_swap;
   logic                  cfg_tuner_byp;
   logic signed [ISZ-1:0] in_i = '0;
   logic signed [ISZ-1:0] in_q = '0;
   logic signed [ISZ-1:0] out_i;
   logic signed [ISZ-1:0] out_q;
   logic [FSZ-1:0]        lo_freq;
   logic                  lo_dir;
   logic                  lo_ns_en;
   logic                  iq_swap;
   logic                  tuner_byp;
   logic                  busy;
   logic                  applied_stb;

   cfg_t drv = '0;
   cfg_t cur = '0;
   cfg_t exp_q[$];

   int n_chk = 0;
   int n_fail = 0;
   int busy_cnt = 0;
   int zero_cnt = 0;
   int stb_cnt = 0;
   int xfer_cnt = 0;
   int stb_per = 0;
   int stb_ctr = 0;

   assign cfg_lo_freq   = drv.f;
   assign cfg_lo_dir    = drv.dir;
   assign cfg_lo_ns_en  = drv.ns;
   assign cfg_iq_swap   = drv.sw;
   assign cfg_tuner_byp = drv.byp;

   always #5 clk = ~clk;

   qduc_cfg_sequencer #(
      .ISZ(ISZ), .FSZ(FSZ), .DRAIN_CYCLES(DRN), .SETTLE_CYCLES(STL), .CW(16)
   ) dut (
      .clk(clk), .reset(reset), .sync_stb(sync_stb),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_lo_freq(cfg_lo_freq), .cfg_lo_dir(cfg_lo_dir), .cfg_lo_ns_en(cfg_lo_ns_en),
      .cfg_iq_swap(cfg_iq_swap), .cfg_tuner_byp(cfg_tuner_byp),
      .in_i(in_i), .in_q(in_q), .out_i(out_i), .out_q(out_q),
      .lo_freq(lo_freq), .lo_dir(lo_dir), .lo_ns_en(lo_ns_en),
      .iq_swap(iq_swap), .tuner_byp(tuner_byp),
      .busy(busy), .applied_stb(applied_stb)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic cfg_t applied_now();
      return cfg_t'({lo_freq, lo_dir, lo_ns_en, iq_swap, tuner_byp});
   endfunction

   // One clock: scoreboard push on handshake, pop on applied_stb, per-cycle applied check
   task automatic tick();
      logic xfer;
      xfer = cfg_valid && cfg_ready && reset;
      @(posedge clk);
      #1;
      if (xfer) begin
         exp_q.push_back(drv);
         xfer_cnt++;
      end
      if (applied_stb) begin
         stb_cnt++;
         if (exp_q.size() == 0) chk("spurious_applied_stb", 64'(1), 64'(0));
         else                   cur = exp_q.pop_front();
      end
      chk("applied_cfg", 64'(applied_now()), 64'(cur));
      if (busy) busy_cnt++;
      if (out_i == 0) zero_cnt++;
      if (stb_per != 0) begin
         stb_ctr  = (stb_ctr + 1) % stb_per;
         sync_stb = (stb_ctr == 0);
      end
   endtask

   task automatic send(input cfg_t c, input logic with_stb);
      int n;
      n = 0;
      drv = c;
      cfg_valid = 1'b1;
      while (!cfg_ready && n < 1000) begin
         tick();
         n++;
      end
      chk("ready_wait", 64'(n < 1000), 64'(1));
      if (with_stb) sync_stb = 1'b1;
      tick();
      cfg_valid = 1'b0;
      if (stb_per == 0) sync_stb = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || !cfg_ready || exp_q.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      chk("idle_wait", 64'(n < 2000), 64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      cfg_t c;
      cfg_t a;
      cfg_t b;
      int   s0;
      int   n;
      int   x0;

      // Reset state and passthrough latency
      in_i = 16'h1234;
      in_q = 16'h0ABC;
      repeat (3) tick();
      chk("rst_out_i", 64'(out_i), 64'(0));
      chk("rst_out_q", 64'(out_q), 64'(0));
      chk("rst_ready", 64'(cfg_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_applied_stb", 64'(applied_stb), 64'(0));
      reset = 1'b1;
      repeat (4) tick();
      chk("pass_out_i", 64'(out_i), 64'(16'h1234));
      chk("pass_out_q", 64'(out_q), 64'(in_q));
      chk("idle_ready", 64'(cfg_ready), 64'(1));
      chk("idle_busy", 64'(busy), 64'(0));
      in_i = 16'h5678;
      tick();
      chk("pass_latency", 64'(out_i), 64'(16'h5678));

      // Glitchless retune, strobe 40 cycles after capture
      in_i = 16'h4000;
      in_q = 16'hC000;
      tick();
      busy_cnt = 0;
      zero_cnt = 0;
      s0 = stb_cnt;
      c = cur;
      c.f = 31'h0CCCCCCD;
      send(c, 1'b0);
      chk("g_busy", 64'(busy), 64'(1));
      repeat (39) tick();
      sync_stb = 1'b1;
      tick();
      sync_stb = 1'b0;
      chk("g_apply_cycle_stb", 64'(applied_stb), 64'(0));
      chk("g_apply_cycle_freq", 64'(lo_freq), 64'(0));
      tick();
      chk("g_visible_stb", 64'(applied_stb), 64'(1));
      chk("g_visible_freq", 64'(lo_freq), 64'(31'h0CCCCCCD));
      repeat (3) tick();
      chk("g_busy_len", 64'(busy_cnt), 64'(42));
      chk("g_no_mute", 64'(zero_cnt), 64'(0));
      chk("g_stb_count", 64'(stb_cnt - s0), 64'(1));
      chk("g_ready_back", 64'(cfg_ready), 64'(1));

      // Disruptive: tuner bypass 0->1
      c = cur;
      c.byp = 1'b1;
      send(c, 1'b0);
      chk("d_mute_i", 64'(out_i), 64'(0));
      chk("d_mute_q", 64'(out_q), 64'(0));
      repeat (20) tick();
      chk("d_mute_wait", 64'(out_i), 64'(0));
      sync_stb = 1'b1;
      zero_cnt = 0;
      tick();
      sync_stb = 1'b0;
      n = 1;
      while (!tuner_byp && n < 50) begin
         tick();
         n++;
      end
      chk("d_byp_delay", 64'(n), 64'(DRN + 2));
      chk("d_mute_drain", 64'(zero_cnt), 64'(n));
      chk("d_applied_stb", 64'(applied_stb), 64'(1));
      zero_cnt = 0;
      repeat (118) tick();
      chk("d_mute_settle", 64'(zero_cnt), 64'(118));
      chk("d_busy_settle", 64'(busy), 64'(1));
      sync_stb = 1'b1;
      tick();
      sync_stb = 1'b0;
      chk("d_resume_i", 64'(out_i), 64'(in_i));
      chk("d_resume_q", 64'(out_q), 64'(in_q));
      repeat (3) tick();
      chk("d_idle_busy", 64'(busy), 64'(0));
      chk("d_idle_ready", 64'(cfg_ready), 64'(1));

      // Back-to-back with cfg_valid held: A then B
      stb_per = 16;
      stb_ctr = 0;
      s0 = stb_cnt;
      x0 = xfer_cnt;
      a = cur;
      a.f = 31'h11111111;
      b = cur;
      b.f = 31'h22222222;
      drv = a;
      cfg_valid = 1'b1;
      tick();
      drv = b;
      n = 0;
      while (xfer_cnt < x0 + 2 && n < 500) begin
         tick();
         n++;
      end
      chk("b2b_second_xfer", 64'(n < 500), 64'(1));
      cfg_valid = 1'b0;
      drv.f = 31'h7FFFFFFF;
      wait_idle();
      chk("b2b_stb_count", 64'(stb_cnt - s0), 64'(2));
      chk("b2b_final_freq", 64'(lo_freq), 64'(31'h22222222));
      stb_per = 0;
      sync_stb = 1'b0;

      // Reset asserted in DRAIN: pending config discarded
      c = cur;
      c.sw = 1'b1;
      send(c, 1'b0);
      repeat (5) tick();
      sync_stb = 1'b1;
      tick();
      sync_stb = 1'b0;
      repeat (3) tick();
      chk("r_busy_drain", 64'(busy), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("r_async_out", 64'(out_i), 64'(0));
      chk("r_async_busy", 64'(busy), 64'(0));
      chk("r_async_byp", 64'(tuner_byp), 64'(0));
      chk("r_async_freq", 64'(lo_freq), 64'(0));
      cur = '0;
      exp_q.delete();
      repeat (2) tick();
      reset = 1'b1;
      stb_per = 32;
      stb_ctr = 0;
      s0 = stb_cnt;
      repeat (200) tick();
      chk("r_no_apply", 64'(stb_cnt - s0), 64'(0));
      chk("r_swap_zero", 64'(iq_swap), 64'(0));
      stb_per = 0;
      sync_stb = 1'b0;
      tick();

      // Capture coincident with sync_stb: use the following strobe
      c = cur;
      c.f = 31'h0ABCDEF0;
      send(c, 1'b1);
      s0 = stb_cnt;
      repeat (127) tick();
      chk("c_no_early_apply", 64'(stb_cnt - s0), 64'(0));
      chk("c_busy", 64'(busy), 64'(1));
      sync_stb = 1'b1;
      tick();
      sync_stb = 1'b0;
      chk("c_apply_cycle_stb", 64'(applied_stb), 64'(0));
      tick();
      chk("c_visible_stb", 64'(applied_stb), 64'(1));
      chk("c_visible_freq", 64'(lo_freq), 64'(31'h0ABCDEF0));

      // Identical config still sequenced as glitchless
      wait_idle();
      c = cur;
      zero_cnt = 0;
      s0 = stb_cnt;
      send(c, 1'b0);
      repeat (3) tick();
      sync_stb = 1'b1;
      tick();
      sync_stb = 1'b0;
      wait_idle();
      chk("same_stb_count", 64'(stb_cnt - s0), 64'(1));
      chk("same_no_mute", 64'(zero_cnt), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
